// File: rtl/muldiv_pkg.sv
// Shared encodings for the sequential multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_MULU = 2'b01,
        OP_DIV  = 2'b10,
        OP_DIVU = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } state_e;

    function automatic logic op_is_signed(input op_e o);
        return ~o[0];
    endfunction

    function automatic logic op_is_div(input op_e o);
        return o[1];
    endfunction

endpackage

// File: rtl/muldiv_seq_unit_cond_negate.sv
// Two's-complement conditional negation: o_val = i_neg ? -i_val : i_val.
module cond_negate #(
    parameter int W = 32
) (
    input  logic         i_neg,
    input  logic [W-1:0] i_val,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? ('0 - i_val) : i_val;

endmodule

// File: rtl/muldiv_seq_unit.sv
// Multi-cycle signed/unsigned multiply and divide producing HI/LO with a start/done handshake.
module muldiv_seq_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_e               r_state;
    op_e                  r_op;
    logic [WIDTH-1:0]     r_a, r_b, r_ma, r_mb;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_cnt;

    logic                 w_sgn, w_div, w_neg_q, w_neg_r;
    logic [WIDTH-1:0]     w_ma, w_mb, w_quot, w_rem;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH:0]       w_msum, w_rsh;
    logic [WIDTH-1:0]     w_rdiff, w_rnew;
    logic                 w_ge;

    assign w_sgn   = op_is_signed(r_op);
    assign w_div   = op_is_div(r_op);
    assign w_neg_q = w_sgn & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
    assign w_neg_r = w_sgn & r_a[WIDTH-1];

    cond_negate #(.W(WIDTH))   u_mag_a (.i_neg(w_neg_r),                 .i_val(r_a),               .o_val(w_ma));
    cond_negate #(.W(WIDTH))   u_mag_b (.i_neg(w_sgn & r_b[WIDTH-1]),    .i_val(r_b),               .o_val(w_mb));
    cond_negate #(.W(2*WIDTH)) u_prod  (.i_neg(w_neg_q),                 .i_val(r_acc),             .o_val(w_prod));
    cond_negate #(.W(WIDTH))   u_quot  (.i_neg(w_neg_q),                 .i_val(r_acc[WIDTH-1:0]),  .o_val(w_quot));
    cond_negate #(.W(WIDTH))   u_rem   (.i_neg(w_neg_r),                 .i_val(r_acc[2*WIDTH-1:WIDTH]), .o_val(w_rem));

    // Multiply: accumulator is {partial product, remaining multiplier bits}, shifted right each step.
    assign w_msum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_ma} : '0);

    // Divide: accumulator is {remainder, dividend/quotient}; quotient bits shift in at the bottom.
    assign w_rsh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_ge    = w_rsh >= {1'b0, r_mb};
    assign w_rdiff = w_rsh[WIDTH-1:0] - r_mb;
    assign w_rnew  = w_ge ? w_rdiff : w_rsh[WIDTH-1:0];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_MUL;
            r_a         <= '0;
            r_b         <= '0;
            r_ma        <= '0;
            r_mb        <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_op        <= op_e'(op);
                        r_a         <= a;
                        r_b         <= b;
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        r_state     <= ST_PREP;
                    end else begin
                        r_state     <= ST_IDLE;
                    end
                end
                ST_PREP: begin
                    r_ma  <= w_ma;
                    r_mb  <= w_mb;
                    r_cnt <= CW'(WIDTH);
                    r_acc <= {{WIDTH{1'b0}}, (w_div ? w_ma : w_mb)};
                    if (w_div && (r_b == '0)) begin
                        hi          <= r_a;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        r_state     <= ST_DONE;
                    end else begin
                        r_state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_div ? {w_rnew, r_acc[WIDTH-2:0], w_ge}
                                   : {w_msum, r_acc[WIDTH-1:1]};
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (w_div) begin
                        hi <= w_rem;
                        lo <= w_quot;
                    end else begin
                        {hi, lo} <= w_prod;
                    end
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Directed-vector bench for muldiv_seq_unit at WIDTH=32 and WIDTH=8.
module tb_muldiv_seq_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, dz;
    logic [31:0] hi, lo;

    logic        st8 = 1'b0;
    logic [1:0]  op8 = 2'b00;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, dz8;
    logic [7:0]  hi8, lo8;

    int n_total = 0;
    int n_bad   = 0;
    int g_busy;
    logic g_dz_early;
    bit poke = 1'b0;

    always #5 clk = ~clk;

    muldiv_seq_unit #(.WIDTH(32)) dut (
        .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(dz)
    );

    muldiv_seq_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .clr(clr), .start(st8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_by_zero(dz8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge; drives the request immediately and counts edges until done.
    task automatic do_op(input string tg, input bit w8, input logic [1:0] f_op,
                         input logic [31:0] f_a, input logic [31:0] f_b, input int e_lat,
                         input logic [31:0] e_hi, input logic [31:0] e_lo, input logic e_dz,
                         input bit pulse_chk);
        int lat;
        logic got_done;
        lat = 0;
        g_busy = 0;
        got_done = 1'b0;
        if (w8) begin
            st8 = 1'b1; op8 = f_op; a8 = f_a[7:0]; b8 = f_b[7:0];
        end else begin
            start = 1'b1; op = f_op; a = f_a; b = f_b;
        end
        while (lat < 200 && !got_done) begin
            @(posedge clk);
            #1;
            lat++;
            start = 1'b0;
            st8 = 1'b0;
            if (poke && lat == 4) begin
                start = 1'b1; op = ~f_op; a = ~f_a; b = f_b + 32'd1;
            end
            if (lat == 1) g_dz_early = w8 ? dz8 : dz;
            if (w8 ? busy8 : busy) g_busy++;
            got_done = w8 ? done8 : done;
        end
        check({tg, ".lat"}, 64'(lat), 64'(e_lat));
        check({tg, ".hi"}, w8 ? {56'h0, hi8} : {32'h0, hi}, {32'h0, e_hi});
        check({tg, ".lo"}, w8 ? {56'h0, lo8} : {32'h0, lo}, {32'h0, e_lo});
        check({tg, ".dz"}, 64'(w8 ? dz8 : dz), 64'(e_dz));
        if (pulse_chk) begin
            @(posedge clk);
            #1;
            check({tg, ".pulse"}, 64'(w8 ? done8 : done), 64'h0);
        end
    endtask

    initial begin
        int done_seen;
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy", 64'(busy), 64'h0);
        check("rst.done", 64'(done), 64'h0);
        check("rst.hi",   64'(hi),   64'h0);
        check("rst.lo",   64'(lo),   64'h0);
        check("rst.dz",   64'(dz),   64'h0);
        #3 clr = 1'b1;
        @(posedge clk);
        #1;

        do_op("mulu", 0, OP_MULU, 32'h12, 32'h14, 35, 32'h0, 32'h168, 1'b0, 1);
        check("mulu.busy", 64'(g_busy), 64'd34);
        do_op("divu", 0, OP_DIVU, 32'h18, 32'h14, 35, 32'h4, 32'h1, 1'b0, 1);
        do_op("mul_neg", 0, OP_MUL, 32'hFFFFFFFD, 32'h5, 35, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1);
        do_op("div_neg", 0, OP_DIV, 32'hFFFFFFF9, 32'h2, 35, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1);
        do_op("div_negb", 0, OP_DIV, 32'h7, 32'hFFFFFFFE, 35, 32'h1, 32'hFFFFFFFD, 1'b0, 1);

        do_op("div0", 0, OP_DIV, 32'h18, 32'h0, 2, 32'h18, 32'hFFFFFFFF, 1'b1, 1);
        check("div0.busy", 64'(g_busy), 64'd1);
        check("div0.hold", 64'(dz), 64'h1);
        do_op("divu_after0", 0, OP_DIVU, 32'd100, 32'd7, 35, 32'd2, 32'd14, 1'b0, 1);
        check("dz.clear_on_start", 64'(g_dz_early), 64'h0);

        do_op("mulu_max", 0, OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 35, 32'hFFFFFFFE, 32'h1, 1'b0, 1);
        do_op("mul_min", 0, OP_MUL, 32'h80000000, 32'h80000000, 35, 32'h40000000, 32'h0, 1'b0, 1);
        poke = 1'b1;
        do_op("ignore_start", 0, OP_MULU, 32'h1234, 32'h10, 35, 32'h0, 32'h12340, 1'b0, 1);
        poke = 1'b0;

        do_op("div_minm1", 0, OP_DIV, 32'h80000000, 32'hFFFFFFFF, 35, 32'h0, 32'h80000000, 1'b0, 0);
        do_op("b2b", 0, OP_MULU, 32'd7, 32'd6, 35, 32'h0, 32'h2A, 1'b0, 1);

        start = 1'b1; op = OP_MULU; a = 32'd5; b = 32'd5;
        repeat (10) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check("midrun.busy", 64'(busy), 64'h1);
        #2 clr = 1'b0;
        #1;
        check("arst.busy", 64'(busy), 64'h0);
        check("arst.done", 64'(done), 64'h0);
        check("arst.hi",   64'(hi),   64'h0);
        check("arst.lo",   64'(lo),   64'h0);
        check("arst.dz",   64'(dz),   64'h0);
        repeat (2) @(posedge clk);
        #3 clr = 1'b1;
        done_seen = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (done || busy) done_seen++;
        end
        check("arst.no_done", 64'(done_seen), 64'h0);

        do_op("w8.mulu", 1, OP_MULU, 32'h12, 32'h14, 11, 32'h01, 32'h68, 1'b0, 1);
        check("w8.busy", 64'(g_busy), 64'd10);
        do_op("w8.divu", 1, OP_DIVU, 32'h18, 32'h14, 11, 32'h04, 32'h01, 1'b0, 1);
        do_op("w8.mul",  1, OP_MUL,  32'hFD, 32'h05, 11, 32'hFF, 32'hF1, 1'b0, 1);
        do_op("w8.div",  1, OP_DIV,  32'hF9, 32'h02, 11, 32'hFF, 32'hFD, 1'b0, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
